// File: rtl/cordic_pkg.sv
// Shared constants, types and helpers for the pipelined phase-to-sine/cosine CORDIC.
// Internal x/y carry XY_FRAC fractional bits so per-stage truncation stays well below one output LSB.
package cordic_pkg;

    localparam int PHASE_W   = 20;
    localparam int OUT_W     = 16;
    localparam int N_ITER    = 16;
    localparam int Z_W       = 24;
    localparam int XY_W      = 20;
    localparam int XY_FRAC   = 3;
    localparam int AMPLITUDE = 32000;
    localparam int SAT_MAX   = 32767;
    localparam int X0        = 19432;
    localparam int LATENCY   = N_ITER + 2;

    // Residual phase bits below the quadrant field, and their alignment into the angle word.
    localparam int RES_W   = PHASE_W - 3;
    localparam int Z_SHIFT = Z_W - (PHASE_W - 1);
    localparam int Z_PAD   = Z_W - RES_W - Z_SHIFT;

    localparam logic signed [XY_W-1:0] X0_INIT = XY_W'(X0 << XY_FRAC);

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_t;

    // round(atan(2^-i) * 2^Z_W / (2*pi))
    function automatic logic [Z_W-1:0] atan_const(input int idx);
        case (idx)
            0:       return 24'd2097152;
            1:       return 24'd1238021;
            2:       return 24'd654136;
            3:       return 24'd332050;
            4:       return 24'd166669;
            5:       return 24'd83416;
            6:       return 24'd41718;
            7:       return 24'd20860;
            8:       return 24'd10430;
            9:       return 24'd5215;
            10:      return 24'd2608;
            11:      return 24'd1304;
            12:      return 24'd652;
            13:      return 24'd326;
            14:      return 24'd163;
            15:      return 24'd81;
            default: return '0;
        endcase
    endfunction

    // Drop the fractional guard bits with round-half-up, then clamp symmetrically.
    function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [XY_W-1:0] v);
        logic signed [XY_W:0] ext;
        logic signed [XY_W:0] half;
        logic signed [XY_W:0] r;
        logic signed [XY_W:0] hi;
        logic signed [XY_W:0] lo;
        ext  = $signed({v[XY_W-1], v});
        half = $signed((XY_W+1)'(1 << (XY_FRAC - 1)));
        r    = (ext + half) >>> XY_FRAC;
        hi   = $signed((XY_W+1)'(SAT_MAX));
        lo   = -hi;
        if (r > hi) begin
            return OUT_W'(hi);
        end else if (r < lo) begin
            return OUT_W'(lo);
        end
        return OUT_W'(r);
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation; the quadrant rides along untouched.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int STAGE = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [XY_W-1:0] x,
    input  logic signed [XY_W-1:0] y,
    input  logic signed [Z_W-1:0]  z,
    input  quad_t                  q,
    output logic signed [XY_W-1:0] x_reg,
    output logic signed [XY_W-1:0] y_reg,
    output logic signed [Z_W-1:0]  z_reg,
    output quad_t                  q_reg
);

    localparam logic signed [Z_W-1:0] ATAN_I = $signed(atan_const(STAGE));

    logic signed [XY_W-1:0] x_shift;
    logic signed [XY_W-1:0] y_shift;
    logic signed [XY_W-1:0] x_next;
    logic signed [XY_W-1:0] y_next;
    logic signed [Z_W-1:0]  z_next;

    always_comb begin
        x_shift = x >>> STAGE;
        y_shift = y >>> STAGE;
        x_next  = x;
        y_next  = y;
        z_next  = z;
        // Non-negative residual angle rotates counter-clockwise.
        if (!z[Z_W-1]) begin
            x_next = x - y_shift;
            y_next = y + x_shift;
            z_next = z - ATAN_I;
        end else begin
            x_next = x + y_shift;
            y_next = y - x_shift;
            z_next = z + ATAN_I;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg <= '0;
            y_reg <= '0;
            z_reg <= '0;
            q_reg <= QUAD_0;
        end else begin
            x_reg <= x_next;
            y_reg <= y_next;
            z_reg <= z_next;
            q_reg <= q;
        end
    end

endmodule

// File: rtl/cordic_phase_gen.sv
// Fully pipelined phase-to-cos/sin converter: input register, N_ITER rotation stages,
// then quadrant unfolding with rounding and saturation into the output register.
module cordic_phase_gen
    import cordic_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PHASE_W-1:0]      arg,
    output logic signed [OUT_W-1:0] Re_out,
    output logic signed [OUT_W-1:0] Im_out
);

    logic signed [XY_W-1:0] x0_reg;
    logic signed [XY_W-1:0] y0_reg;
    logic signed [Z_W-1:0]  z0_reg;
    quad_t                  q0_reg;

    logic signed [XY_W-1:0] x_pipe [N_ITER];
    logic signed [XY_W-1:0] y_pipe [N_ITER];
    logic signed [Z_W-1:0]  z_pipe [N_ITER];
    quad_t                  q_pipe [N_ITER];

    logic signed [XY_W-1:0] c_fin;
    logic signed [XY_W-1:0] s_fin;
    logic signed [XY_W-1:0] re_next;
    logic signed [XY_W-1:0] im_next;

    // The turn-count bit and the leftover angle are intentionally discarded.
    logic unused_bits;
    assign unused_bits = ^{arg[PHASE_W-1], z_pipe[N_ITER-1]};

    // The rotation only ever sees the first-quadrant residual; the quadrant is reapplied at the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_reg <= '0;
            y0_reg <= '0;
            z0_reg <= '0;
            q0_reg <= QUAD_0;
        end else begin
            x0_reg <= X0_INIT;
            y0_reg <= '0;
            z0_reg <= {{Z_PAD{1'b0}}, arg[RES_W-1:0], {Z_SHIFT{1'b0}}};
            q0_reg <= quad_t'(arg[PHASE_W-2 -: 2]);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_ITER; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                cordic_stage #(
                    .STAGE(gi)
                ) u_stage (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .x     (x0_reg),
                    .y     (y0_reg),
                    .z     (z0_reg),
                    .q     (q0_reg),
                    .x_reg (x_pipe[gi]),
                    .y_reg (y_pipe[gi]),
                    .z_reg (z_pipe[gi]),
                    .q_reg (q_pipe[gi])
                );
            end else begin : g_rest
                cordic_stage #(
                    .STAGE(gi)
                ) u_stage (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .x     (x_pipe[gi-1]),
                    .y     (y_pipe[gi-1]),
                    .z     (z_pipe[gi-1]),
                    .q     (q_pipe[gi-1]),
                    .x_reg (x_pipe[gi]),
                    .y_reg (y_pipe[gi]),
                    .z_reg (z_pipe[gi]),
                    .q_reg (q_pipe[gi])
                );
            end
        end
    endgenerate

    assign c_fin = x_pipe[N_ITER-1];
    assign s_fin = y_pipe[N_ITER-1];

    always_comb begin
        re_next = c_fin;
        im_next = s_fin;
        case (q_pipe[N_ITER-1])
            QUAD_0: begin
                re_next = c_fin;
                im_next = s_fin;
            end
            QUAD_1: begin
                re_next = -s_fin;
                im_next = c_fin;
            end
            QUAD_2: begin
                re_next = -c_fin;
                im_next = -s_fin;
            end
            QUAD_3: begin
                re_next = s_fin;
                im_next = -c_fin;
            end
            default: begin
                re_next = c_fin;
                im_next = s_fin;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Re_out <= '0;
            Im_out <= '0;
        end else begin
            Re_out <= round_sat(re_next);
            Im_out <= round_sat(im_next);
        end
    end

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Directed-vector bench for cordic_phase_gen: reset, latency, angles, quadrant edges, streaming, mid-stream reset.
module tb_cordic_phase_gen;

    localparam int TOL = 4;
    localparam int LAT = 18;
    localparam int NV  = 13;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [19:0]         arg;
    logic signed [15:0]  Re_out;
    logic signed [15:0]  Im_out;

    int errors = 0;
    int checks = 0;

    int vec_arg [NV] = '{0, 131072, 262144, 393216, 65536, 524288, 524287,
                         43691, 87381, 174763, 305835, 436907, 131071};
    int vec_re  [NV] = '{32000, 0, -32000, 0, 22627, 32000, 32000,
                         27713, 16000, -16000, -27713, 16000, 0};
    int vec_im  [NV] = '{0, 32000, 0, -32000, 22627, 0, 0,
                         16000, 27713, 27713, -16000, -27713, 32000};

    cordic_phase_gen dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arg    (arg),
        .Re_out (Re_out),
        .Im_out (Im_out)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int absd(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    task automatic test_reset;
        int re;
        int im;
        rst_n = 1'b0;
        arg   = 20'd0;
        tick(3);
        checks++;
        if (Re_out !== 16'sd0 || Im_out !== 16'sd0) begin
            errors++;
            $display("FAIL reset_hold: got Re=%0d Im=%0d, want 0 0", Re_out, Im_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(LAT - 1);
        checks++;
        if (Re_out !== 16'sd0 || Im_out !== 16'sd0) begin
            errors++;
            $display("FAIL reset_pre_valid: got Re=%0d Im=%0d, want 0 0", Re_out, Im_out);
        end
        tick(1);
        re = Re_out;
        im = Im_out;
        checks++;
        if (absd(re, 32000) > TOL || absd(im, 0) > TOL) begin
            errors++;
            $display("FAIL reset_first_valid: got Re=%0d Im=%0d, want 32000 0", re, im);
        end
        $display("reset: first valid sample Re=%0d Im=%0d", re, im);
    endtask

    task automatic test_directed;
        int re;
        int im;
        for (int k = 0; k < NV; k++) begin
            arg = 20'(vec_arg[k]);
            tick(LAT);
            re = Re_out;
            im = Im_out;
            checks++;
            if (absd(re, vec_re[k]) > TOL) begin
                errors++;
                $display("FAIL directed_re arg=%0d: got %0d, want %0d", vec_arg[k], re, vec_re[k]);
            end
            checks++;
            if (absd(im, vec_im[k]) > TOL) begin
                errors++;
                $display("FAIL directed_im arg=%0d: got %0d, want %0d", vec_arg[k], im, vec_im[k]);
            end
            $display("directed arg=%0d Re=%0d Im=%0d", vec_arg[k], re, im);
        end
    endtask

    task automatic test_quadrant_ramp;
        int edges [4] = '{131072, 262144, 393216, 524288};
        int re;
        int im;
        int prev_re;
        int prev_im;
        for (int e = 0; e < 4; e++) begin
            prev_re = 0;
            prev_im = 0;
            for (int j = 0; j < 16 + LAT; j++) begin
                if (j < 16) begin
                    arg = 20'(edges[e] - 8 + j);
                end
                tick(1);
                re = Re_out;
                im = Im_out;
                if (j >= LAT) begin
                    checks++;
                    if (absd(re, prev_re) > 2 * TOL || absd(im, prev_im) > 2 * TOL) begin
                        errors++;
                        $display("FAIL ramp_step edge=%0d idx=%0d: got Re=%0d Im=%0d after Re=%0d Im=%0d, want step <= %0d",
                                 edges[e], j - (LAT - 1), re, im, prev_re, prev_im, 2 * TOL);
                    end
                    $display("ramp edge=%0d arg=%0d Re=%0d Im=%0d", edges[e], edges[e] - 8 + j - (LAT - 1), re, im);
                end
                prev_re = re;
                prev_im = im;
            end
        end
    endtask

    task automatic test_back_to_back;
        int re;
        int want;
        arg = 20'd0;
        tick(LAT);
        for (int j = 0; j < 40; j++) begin
            arg = (j % 2 == 1) ? 20'd262144 : 20'd0;
            tick(1);
            re = Re_out;
            if (j >= LAT - 1) begin
                want = ((j - (LAT - 1)) % 2 == 1) ? -32000 : 32000;
            end else begin
                want = 32000;
            end
            checks++;
            if (absd(re, want) > TOL) begin
                errors++;
                $display("FAIL back_to_back cycle=%0d: got Re=%0d, want %0d", j, re, want);
            end
            $display("b2b cycle=%0d Re=%0d Im=%0d", j, re, Im_out);
        end
    endtask

    task automatic test_reset_midstream;
        int re;
        arg = 20'd0;
        tick(LAT);
        re = Re_out;
        checks++;
        if (absd(re, 32000) > TOL) begin
            errors++;
            $display("FAIL midstream_before: got Re=%0d, want 32000", re);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (Re_out !== 16'sd0 || Im_out !== 16'sd0) begin
            errors++;
            $display("FAIL midstream_async_clear: got Re=%0d Im=%0d, want 0 0", Re_out, Im_out);
        end
        tick(2);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 1; j < LAT; j++) begin
            tick(1);
            checks++;
            if (Re_out !== 16'sd0 || Im_out !== 16'sd0) begin
                errors++;
                $display("FAIL midstream_refill clk=%0d: got Re=%0d Im=%0d, want 0 0", j, Re_out, Im_out);
            end
        end
        tick(1);
        re = Re_out;
        checks++;
        if (absd(re, 32000) > TOL || absd(int'(Im_out), 0) > TOL) begin
            errors++;
            $display("FAIL midstream_revalid: got Re=%0d Im=%0d, want 32000 0", re, Im_out);
        end
        $display("midstream reset: valid again after %0d clocks Re=%0d Im=%0d", LAT, re, Im_out);
    endtask

    initial begin
        rst_n = 1'b0;
        arg   = 20'd0;
        test_reset();
        test_directed();
        test_quadrant_ramp();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
